// File: rtl/lane_array_sched_if.sv
// Issue/retire bundle between the warp issue stage and lane_array_sched.
// The scheduler takes the slave side; the issue stage (or a bench) takes the master side.
interface lane_array_sched_if #(
    parameter int NUM_LANES = 8
) ();
    logic                 issue_valid;
    logic                 issue_ready;
    logic [31:0]          issue_inst;
    logic [NUM_LANES-1:0] issue_mask;
    logic [NUM_LANES-1:0] lane_stall;
    logic                 flush;
    logic [NUM_LANES-1:0] lane_busy;
    logic                 busy;
    logic                 ready;
    logic                 done;
    logic [31:0]          done_inst;
    logic [NUM_LANES-1:0] done_mask;

    modport master (
        output issue_valid, issue_inst, issue_mask, lane_stall, flush,
        input  issue_ready, lane_busy, busy, ready, done, done_inst, done_mask
    );

    modport slave (
        input  issue_valid, issue_inst, issue_mask, lane_stall, flush,
        output issue_ready, lane_busy, busy, ready, done, done_inst, done_mask
    );
endinterface

// File: rtl/lane_array_sched.sv
// Masked SIMD instruction scheduler: in-order issue queue, per-lane latency
// counters with per-lane stall, and an all-lanes barrier that emits a retire pulse.
module lane_array_sched #(
    parameter int NUM_LANES   = 8,
    parameter int QUEUE_DEPTH = 2,
    parameter int LAT_ADD     = 1,
    parameter int LAT_MUL     = 3,
    parameter int LAT_MAX     = 1,
    parameter int LAT_FMA     = 4,
    parameter int LAT_DEFAULT = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    lane_array_sched_if.slave  bus
);

    typedef enum logic [3:0] {
        OP_ADD = 4'h0,
        OP_MUL = 4'h1,
        OP_MAX = 4'h2,
        OP_FMA = 4'h3
    } alu_opcode_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_RETIRE
    } state_e;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int LAT_TOP = max2(max2(max2(LAT_ADD, LAT_MUL), max2(LAT_MAX, LAT_FMA)), LAT_DEFAULT);
    localparam int CNT_W   = $clog2(LAT_TOP + 1);
    localparam int PTR_W   = $clog2(QUEUE_DEPTH);
    localparam int OCC_W   = PTR_W + 1;

    function automatic logic [CNT_W-1:0] lat_of(input logic [3:0] opcode);
        alu_opcode_e op;
        op = alu_opcode_e'(opcode);
        case (op)
            OP_ADD:  lat_of = CNT_W'(LAT_ADD);
            OP_MUL:  lat_of = CNT_W'(LAT_MUL);
            OP_MAX:  lat_of = CNT_W'(LAT_MAX);
            OP_FMA:  lat_of = CNT_W'(LAT_FMA);
            default: lat_of = CNT_W'(LAT_DEFAULT);
        endcase
    endfunction

    // Instruction queue
    logic [31:0]          q_inst [QUEUE_DEPTH];
    logic [NUM_LANES-1:0] q_mask [QUEUE_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_reg;
    logic [PTR_W-1:0]     rd_ptr_reg;
    logic [OCC_W-1:0]     count_reg;

    logic                 full;
    logic                 empty;
    logic                 push;
    logic                 pop;
    logic [31:0]          head_inst;
    logic [NUM_LANES-1:0] head_mask;

    state_e               state_reg;
    state_e               state_next;
    logic [31:0]          cur_inst_reg;
    logic [NUM_LANES-1:0] cur_mask_reg;
    logic [31:0]          done_inst_reg;
    logic [NUM_LANES-1:0] done_mask_reg;
    logic [NUM_LANES-1:0] lane_busy_int;
    logic [CNT_W-1:0]     pop_lat;
    logic                 retire_load;

    assign full      = (count_reg == OCC_W'(QUEUE_DEPTH));
    assign empty     = (count_reg == '0);
    assign head_inst = q_inst[rd_ptr_reg];
    assign head_mask = q_mask[rd_ptr_reg];
    // flush wins over everything, so neither queue port moves in a flush cycle
    assign push      = bus.issue_valid && !full && !bus.flush;
    assign pop       = (state_reg == ST_IDLE) && !empty && !bus.flush;
    assign pop_lat   = lat_of(head_inst[31:28]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (bus.flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_reg <= count_reg + OCC_W'(1);
                2'b01:   count_reg <= count_reg - OCC_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_inst[wr_ptr_reg] <= bus.issue_inst;
            q_mask[wr_ptr_reg] <= bus.issue_mask;
        end
    end

    // Per-lane latency counters
    genvar gi;
    generate
        for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            logic [CNT_W-1:0] cnt_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_reg <= '0;
                end else if (bus.flush) begin
                    cnt_reg <= '0;
                end else if (pop) begin
                    cnt_reg <= head_mask[gi] ? pop_lat : '0;
                end else if (state_reg == ST_EXEC && cnt_reg != '0 && !bus.lane_stall[gi]) begin
                    cnt_reg <= cnt_reg - CNT_W'(1);
                end
            end

            assign lane_busy_int[gi] = (cnt_reg != '0);
        end
    endgenerate

    // Control FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= ST_IDLE;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (!empty) state_next = (head_mask == '0) ? ST_RETIRE : ST_EXEC;
            end
            ST_EXEC: begin
                if (lane_busy_int == '0) state_next = ST_RETIRE;
            end
            ST_RETIRE: state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
        if (bus.flush) state_next = ST_IDLE;
    end

    // A zero-mask op enters RETIRE straight from IDLE, so its result comes from the queue head
    assign retire_load = (state_next == ST_RETIRE) && (state_reg != ST_RETIRE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_inst_reg  <= '0;
            cur_mask_reg  <= '0;
            done_inst_reg <= '0;
            done_mask_reg <= '0;
        end else begin
            if (pop) begin
                cur_inst_reg <= head_inst;
                cur_mask_reg <= head_mask;
            end
            if (retire_load) begin
                done_inst_reg <= (state_reg == ST_IDLE) ? head_inst : cur_inst_reg;
                done_mask_reg <= (state_reg == ST_IDLE) ? head_mask : cur_mask_reg;
            end
        end
    end

    assign bus.issue_ready = !full;
    assign bus.lane_busy   = lane_busy_int;
    assign bus.busy        = (state_reg != ST_IDLE) || !empty;
    assign bus.ready       = (state_reg == ST_IDLE) && empty;
    assign bus.done        = (state_reg == ST_RETIRE);
    assign bus.done_inst   = done_inst_reg;
    assign bus.done_mask   = done_mask_reg;

endmodule

// File: doc/lane_array_sched.md
Name: lane_array_sched

Overview:
Parametrised successor to lane_array. It accepts masked SIMD instructions through a valid/ready issue port and buffers them in a small in-order queue. Each instruction is dispatched to NUM_LANES lanes, each lane holding an opcode-dependent latency counter that can be stalled per lane. Completion is a barrier across all enabled lanes, reported as a one-cycle done pulse carrying the retired instruction and mask. The block sits between the warp issue stage and the lane datapaths.

Parameters:
NUM_LANES, 8, number of lanes (1..32)
QUEUE_DEPTH, 2, instruction queue entries (power of two, >=2)
LAT_ADD, 1, cycles for OP_ADD (>=1)
LAT_MUL, 3, cycles for OP_MUL (>=1)
LAT_MAX, 1, cycles for OP_MAX (>=1)
LAT_FMA, 4, cycles for OP_FMA (>=1)
LAT_DEFAULT, 2, cycles for any other opcode (>=1)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous, active-low reset
issue_valid  in  1  instruction offered
issue_ready  out  1  queue can accept (= !full)
issue_inst  in  32  instruction; opcode in [31:28] (alu_opcode_e)
issue_mask  in  NUM_LANES  lane enable for this instruction
lane_stall  in  NUM_LANES  per-lane hold; freezes that lane's counter
flush  in  1  synchronous abort of queue and in-flight op
lane_busy  out  NUM_LANES  lane has a nonzero counter
busy  out  1  FSM not IDLE or queue non-empty
ready  out  1  FSM IDLE and queue empty
done  out  1  one-cycle retire pulse
done_inst  out  32  instruction retired (valid with done)
done_mask  out  NUM_LANES  mask retired (valid with done)

Behaviour:
- Reset (async, rst_n=0): queue empty, FSM IDLE, counters 0. Outputs: issue_ready=1, ready=1, busy=0, done=0, done_inst=0, done_mask=0, lane_busy=0.
- Accept: issue_valid && issue_ready at a clock edge pushes {inst, mask}. issue_ready depends only on full, so a push into a full queue is refused even if a pop occurs in the same cycle. A simultaneous push and pop on a non-full queue keeps the count unchanged.
- FSM IDLE: if the queue is non-empty, pop the head and latch inst/mask.
  - Mask == 0: go to RETIRE.
  - Otherwise: go to EXEC and load counter[i] = LAT(opcode) for each enabled lane, 0 for the others.
- FSM EXEC: each nonzero counter decrements once per cycle unless lane_stall[i]=1. lane_stall on a disabled or finished lane has no effect. When all counters are 0, go to RETIRE on the next edge.
- FSM RETIRE: done=1 for exactly one cycle with done_inst/done_mask equal to the latched values. Next state is always IDLE. done_inst/done_mask hold their values until the next retire.
- Timing, accept at edge 0, no stalls, FSM idle and queue empty: pop at edge 1, counters reach 0 at edge 1+LAT, done high in the cycle after edge 2+LAT. Zero mask: done high in the cycle after edge 1.
- Back-to-back throughput is one instruction per LAT+3 cycles. Retire order equals accept order.
- Counter width is clog2(max LAT + 1). Latencies are unsigned with no wrap, because counters only decrement to 0.
- flush (synchronous, highest priority over push/pop/FSM): on the next edge, empty the queue, zero all counters, FSM to IDLE, no done pulse. An issue accepted in the flush cycle is discarded. done_inst/done_mask keep their old values.
- Reset asserted mid-operation clears everything immediately. No done pulse is emitted.

Test Plan:
1. Release reset with NUM_LANES=4 -> ready=1, issue_ready=1, busy=0, done=0, lane_busy=0000.
2. Issue ADD (dst1, src2, src3) with mask 1111 at edge 0 -> lane_busy=1111 after edge 1; done high in the cycle after edge 3; done_mask=1111; done_inst matches; ready=1 one cycle later.
3. Issue FMA with mask 0101 and lane_stall=0100 held for 3 cycles after dispatch -> lane 0 clears at edge 5; lane_busy=0100 until edge 8; done after edge 9; done_mask=0101.
4. Issue ADD with mask 0000 -> lane_busy stays 0000; done high in the cycle after edge 1; done_mask=0000; ready=1 afterwards.
5. Hold issue_valid for 4 consecutive MULs with masks 1111, 1110, 1100, 1000 (QUEUE_DEPTH=2) -> issue_ready drops after the 3rd accept and the 4th waits; four done pulses spaced 6 cycles apart, in order, each done_mask matching its instruction.
6. Queue two MAXs, then assert flush while the first is in EXEC -> the next cycle shows lane_busy=0, ready=1, issue_ready=1; no done pulse for either instruction; done_inst unchanged.
